row_column_mac: RTL and testbench

Parametrised, sequential fixed-point dot-product engine for the DCT matrix-multiplication datapath. It computes the sum over N elements of row[i]·column[i] using one signed MAC per cycle. The result is rounded, rescaled by FRAC, and saturated to OUT_W bits. Compared with the single-shot 8-element row/column multiplier, it adds configurable vector length and widths, a ready/valid input handshake, rounding and saturation, and a registered single-cycle result strobe.

---
 rtl/row_column_mac.sv | 138 +++++++++++++
 tb/tb_row_column_mac.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/row_column_mac.sv
// Sequential signed dot-product engine: one MAC per cycle over N captured elements, then
// round, rescale by FRAC and saturate into a registered result with a one-cycle strobe.
module row_column_mac #(
   parameter int unsigned N      = 8,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned FRAC   = 8,
   parameter int unsigned OUT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  validin,
   output logic                  ready,
   input  logic [N*DATA_W-1:0]   row,
   input  logic [N*DATA_W-1:0]   column,
   output logic [OUT_W-1:0]      out,
   output logic                  validity
);

   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned AccW = 2 * DATA_W + $clog2(N);
   localparam int unsigned RndW = AccW + 1;
   localparam int unsigned ProdW = 2 * DATA_W;

   typedef enum logic [0:0] {StIdle, StMac} state_e;

   state_e                state_q, state_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic signed [AccW-1:0] acc_q, acc_d;
   logic [N*DATA_W-1:0]   row_q, row_d;
   logic [N*DATA_W-1:0]   col_q, col_d;
   logic [OUT_W-1:0]      out_q, out_d;
   logic                  validity_q, validity_d;

   logic signed [DATA_W-1:0] row_e [N];
   logic signed [DATA_W-1:0] col_e [N];
   logic signed [DATA_W-1:0] row_sel, col_sel;
   logic signed [ProdW-1:0]  prod;
   logic signed [AccW-1:0]   mac_sum;
   logic signed [RndW-1:0]   rnd_ext;
   logic signed [RndW-1:0]   rnd;
   logic [OUT_W-1:0]         sat_res;
   logic                     last_elem;

   for (genvar i = 0; i < N; i++) begin : g_unpack
      assign row_e[i] = row_q[i*DATA_W +: DATA_W];
      assign col_e[i] = col_q[i*DATA_W +: DATA_W];
   end

   assign row_sel   = row_e[idx_q];
   assign col_sel   = col_e[idx_q];
   assign prod      = row_sel * col_sel;
   assign mac_sum   = acc_q + AccW'(prod);
   assign rnd_ext   = RndW'(mac_sum);
   assign last_elem = (idx_q == IdxW'(N - 1));

   // Half-LSB bias before the arithmetic shift rounds ties toward +infinity.
   if (FRAC > 0) begin : g_round
      localparam logic signed [RndW-1:0] Half = RndW'(1) <<< (FRAC - 1);
      logic signed [RndW-1:0] rnd_sum;
      assign rnd_sum = rnd_ext + Half;
      assign rnd     = rnd_sum >>> FRAC;
   end else begin : g_no_round
      assign rnd = rnd_ext;
   end

   if (OUT_W < RndW) begin : g_sat
      localparam logic signed [RndW-1:0] SatMax =
         {{(RndW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
      localparam logic signed [RndW-1:0] SatMin = ~SatMax;
      always_comb begin
         sat_res = rnd[OUT_W-1:0];
         if (rnd > SatMax) begin
            sat_res = SatMax[OUT_W-1:0];
         end else if (rnd < SatMin) begin
            sat_res = SatMin[OUT_W-1:0];
         end
      end
   end else begin : g_no_sat
      assign sat_res = OUT_W'(rnd);
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      acc_d      = acc_q;
      row_d      = row_q;
      col_d      = col_q;
      out_d      = out_q;
      validity_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (validin) begin
               row_d   = row;
               col_d   = column;
               idx_d   = '0;
               acc_d   = '0;
               state_d = StMac;
            end
         end
         StMac: begin
            acc_d = mac_sum;
            idx_d = idx_q + IdxW'(1);
            if (last_elem) begin
               out_d      = sat_res;
               validity_d = 1'b1;
               idx_d      = '0;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         acc_q      <= '0;
         row_q      <= '0;
         col_q      <= '0;
         out_q      <= '0;
         validity_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         acc_q      <= acc_d;
         row_q      <= row_d;
         col_q      <= col_d;
         out_q      <= out_d;
         validity_q <= validity_d;
      end
   end

   assign ready    = (state_q == StIdle);
   assign out      = out_q;
   assign validity = validity_q;

endmodule

// File: tb/tb_row_column_mac.sv
// Randomized and directed bench for row_column_mac against a cycle-count reference model.
module tb_row_column_mac;

   localparam int unsigned N      = 8;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned FRAC   = 8;
   localparam int unsigned OUT_W  = 16;
   localparam int unsigned VW     = N * DATA_W;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             validin = 1'b0;
   logic [VW-1:0]    row = '0;
   logic [VW-1:0]    column = '0;
   logic             ready;
   logic [OUT_W-1:0] out;
   logic             validity;

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   row_column_mac #(
      .N(N), .DATA_W(DATA_W), .FRAC(FRAC), .OUT_W(OUT_W)
   ) dut (
      .clk(clk), .rst(rst), .validin(validin), .ready(ready),
      .row(row), .column(column), .out(out), .validity(validity)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Exact dot product, then floor((sum + half) / 2^FRAC) and clamp.
   function automatic logic [OUT_W-1:0] ref_dot(input logic [VW-1:0] r, input logic [VW-1:0] c);
      longint sum, num, den, q, lo, hi;
      logic signed [DATA_W-1:0] a, b;
      sum = 0;
      for (int i = 0; i < N; i++) begin
         a = r[i*DATA_W +: DATA_W];
         b = c[i*DATA_W +: DATA_W];
         sum += longint'(a) * longint'(b);
      end
      if (FRAC > 0) begin
         den = longint'(1) << FRAC;
         num = sum + den / 2;
         q = num / den;
         if ((num % den != 0) && (num < 0)) q -= 1;
      end else begin
         q = sum;
      end
      hi = (longint'(1) << (OUT_W - 1)) - 1;
      lo = -(longint'(1) << (OUT_W - 1));
      if (q > hi) q = hi;
      if (q < lo) q = lo;
      return q[OUT_W-1:0];
   endfunction

   function automatic logic [VW-1:0] fill(input logic [DATA_W-1:0] v);
      logic [VW-1:0] r;
      for (int i = 0; i < N; i++) r[i*DATA_W +: DATA_W] = v;
      return r;
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] r;
      for (int i = 0; i < N; i++) begin
         case ($urandom_range(0, 3))
            0:       r[i*DATA_W +: DATA_W] = 16'h7FFF;
            1:       r[i*DATA_W +: DATA_W] = 16'h8000;
            default: r[i*DATA_W +: DATA_W] = DATA_W'($urandom);
         endcase
      end
      return r;
   endfunction

   // Model: busy for N edges after an accept; result appears on the Nth.
   int               busy_left = 0;
   logic [OUT_W-1:0] m_out = '0;
   logic             m_valid = 1'b0;
   logic [OUT_W-1:0] pending = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_left = 0;
         m_out     = '0;
         m_valid   = 1'b0;
      end else begin
         m_valid = 1'b0;
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
               m_out   = pending;
               m_valid = 1'b1;
            end
         end else if (validin) begin
            pending   = ref_dot(row, column);
            busy_left = N;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("ready", 64'(ready), 64'(busy_left == 0));
         chk("validity", 64'(validity), 64'(m_valid));
         chk("out", 64'(out), 64'(m_out));
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!ready && n < 4 * N) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
   endtask

   task automatic run_op(input string name, input logic [VW-1:0] r, input logic [VW-1:0] c,
                         input logic [OUT_W-1:0] exp, input bit noisy);
      int lat;
      wait_ready();
      validin = 1'b1;
      row     = r;
      column  = c;
      @(posedge clk);
      #1;
      validin = 1'b0;
      lat = 0;
      for (int k = 1; k <= 3 * N; k++) begin
         @(posedge clk);
         #1;
         if (validity) begin
            lat = k;
            break;
         end
         if (noisy) begin
            validin = k[0];
            row     = rand_vec();
            column  = rand_vec();
         end
      end
      validin = 1'b0;
      chk({name, "_latency"}, 64'(lat), 64'(N));
      chk({name, "_out"}, 64'(out), 64'(exp));
   endtask

   logic [VW-1:0] v_a, v_b;

   initial begin
      #1 rst = 1'b1;
      started = 1'b1;
      validin = 1'b1;
      row     = fill(16'h0100);
      column  = fill(16'h0100);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", 64'(ready), 64'd1);
      chk("reset_out", 64'(out), 64'd0);
      chk("reset_validity", 64'(validity), 64'd0);
      validin = 1'b0;
      rst     = 1'b0;

      chk("model_basic", 64'(ref_dot(fill(16'h0100), fill(16'h0100))), 64'h0800);
      chk("model_signed", 64'(ref_dot(fill(16'hFF00), fill(16'h0200))), 64'hF000);
      chk("model_sat_pos", 64'(ref_dot(fill(16'h7FFF), fill(16'h7FFF))), 64'h7FFF);
      chk("model_sat_neg", 64'(ref_dot(fill(16'h8000), fill(16'h7FFF))), 64'h8000);

      run_op("basic", fill(16'h0100), fill(16'h0100), 16'h0800, 1'b0);
      run_op("signed", fill(16'hFF00), fill(16'h0200), 16'hF000, 1'b0);
      run_op("sat_pos", fill(16'h7FFF), fill(16'h7FFF), 16'h7FFF, 1'b0);
      run_op("sat_neg", fill(16'h8000), fill(16'h7FFF), 16'h8000, 1'b0);
      v_a = '0; v_a[DATA_W-1:0] = 16'h0001;
      v_b = '0; v_b[DATA_W-1:0] = 16'h0080;
      run_op("rnd_half_up", v_a, v_b, 16'h0001, 1'b0);
      v_b[DATA_W-1:0] = 16'h007F;
      run_op("rnd_below_half", v_a, v_b, 16'h0000, 1'b0);
      v_a[DATA_W-1:0] = 16'hFFFF;
      v_b[DATA_W-1:0] = 16'h0080;
      run_op("rnd_neg_half", v_a, v_b, 16'h0000, 1'b0);
      run_op("busy_ignore", fill(16'hFF00), fill(16'h0200), 16'hF000, 1'b1);

      // Reset three cycles into an operation discards it.
      wait_ready();
      validin = 1'b1;
      row     = fill(16'h0100);
      column  = fill(16'h0100);
      @(posedge clk);
      #1;
      validin = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_validity", 64'(validity), 64'd0);
      chk("midrst_out", 64'(out), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midrst_ready", 64'(ready), 64'd1);
      run_op("after_reset", fill(16'h0100), fill(16'h0100), 16'h0800, 1'b0);

      // Random validin with random operands.
      for (int k = 0; k < 300; k++) begin
         validin = ($urandom_range(0, 9) < 3);
         row     = rand_vec();
         column  = rand_vec();
         @(posedge clk);
         #1;
      end
      // validin held high, operands changing every cycle.
      for (int k = 0; k < 120; k++) begin
         validin = 1'b1;
         row     = rand_vec();
         column  = rand_vec();
         @(posedge clk);
         #1;
      end
      validin = 1'b0;
      repeat (2 * N) @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
